// File: rtl/fifo_word_packer_pkg.sv
// Shared widths, keep codes, beat layout and FSM encoding for the FIFO word packer.
// Imported by the interface, the idle timer and the packer top.
package fifo_pkg;

  localparam int WORD_W = 16;
  localparam int BEAT_W = 32;

  localparam logic [1:0] KEEP_FULL = 2'b11;
  localparam logic [1:0] KEEP_HALF = 2'b01;

  typedef enum logic [1:0] {
    FILL_LO,
    FILL_HI,
    SEND
  } packer_state_e;

  // hi occupies [31:16], lo (first word popped) occupies [15:0]
  typedef struct packed {
    logic [WORD_W-1:0] hi;
    logic [WORD_W-1:0] lo;
  } beat_t;

endpackage

// File: rtl/fifo_word_packer_if.sv
// FIFO read port plus outbound beat stream of the packer; master = packer side.
// Single-cycle read pulse toward the FIFO, valid/ready toward the consumer.
interface fifo_word_packer_if;
  import fifo_pkg::*;

  logic              fifo_empty;
  logic              fifo_re;
  logic [WORD_W-1:0] fifo_dout;
  logic              flush;
  logic              m_valid;
  logic              m_ready;
  beat_t             m_data;
  logic [1:0]        m_keep;
  logic [15:0]       beat_cnt;

  modport master (
    input  fifo_empty, fifo_dout, flush, m_ready,
    output fifo_re, m_valid, m_data, m_keep, beat_cnt
  );

  modport slave (
    output fifo_empty, fifo_dout, flush, m_ready,
    input  fifo_re, m_valid, m_data, m_keep, beat_cnt
  );

endinterface

// File: rtl/fifo_word_packer_timer.sv
// Idle counter: counts enabled cycles after clr, expired is combinational at TIMEOUT-1.
// Saturates at expiry; TIMEOUT=0 never expires. No backpressure.
module pack_timer #(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

  logic [15:0] cnt;

  assign expired = (TIMEOUT != 0) && (cnt == CNT_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && !expired) begin
      cnt <= cnt + 16'd1;
    end
  end

endmodule

// File: rtl/fifo_word_packer.sv
// Pops 16-bit words, packs pairs into 32-bit beats; half beat on flush or idle timeout.
// Latency: beat valid 4 cycles after first read; holds beat stable while m_ready is low.
module fifo_word_packer
  import fifo_pkg::*;
#(
  parameter int unsigned TIMEOUT = 64
) (
  input logic               clk,
  input logic               rst,
  fifo_word_packer_if.master pk
);

  packer_state_e     state, state_nxt;
  logic              pending;
  logic [WORD_W-1:0] lo, hi;
  logic [1:0]        keep;
  logic [15:0]       beat_cnt;
  logic              expired;
  logic              flush_take;
  logic              rd;
  logic              accept;

  always_comb begin
    flush_take = (state == FILL_HI) && !pending && (pk.flush || expired);
    // Reset gating keeps the read strobe low while the block is held in reset.
    rd         = rst && ((state == FILL_LO) || (state == FILL_HI)) && !pending &&
                 !pk.fifo_empty && !flush_take;
    accept     = (state == SEND) && pk.m_ready;
    state_nxt  = state;
    case (state)
      FILL_LO: if (pending) state_nxt = FILL_HI;
      FILL_HI: if (pending || flush_take) state_nxt = SEND;
      SEND:    if (pk.m_ready) state_nxt = FILL_LO;
      default: state_nxt = FILL_LO;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= FILL_LO;
      pending  <= 1'b0;
      lo       <= '0;
      hi       <= '0;
      keep     <= '0;
      beat_cnt <= '0;
    end else begin
      state   <= state_nxt;
      // rd is never high while pending, so this also clears pending after capture
      pending <= rd;
      if (pending && (state == FILL_LO)) begin
        lo <= pk.fifo_dout;
      end
      if (pending && (state == FILL_HI)) begin
        hi   <= pk.fifo_dout;
        keep <= KEEP_FULL;
      end else if (flush_take) begin
        hi   <= '0;
        keep <= KEEP_HALF;
      end
      if (accept) begin
        beat_cnt <= beat_cnt + 16'd1;
      end
    end
  end

  pack_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clr     (((state == FILL_LO) && pending) || rd),
    .en      ((state == FILL_HI) && !pending),
    .expired (expired)
  );

  assign pk.fifo_re  = rd;
  assign pk.m_valid  = (state == SEND);
  assign pk.m_data   = '{hi: hi, lo: lo};
  assign pk.m_keep   = keep;
  assign pk.beat_cnt = beat_cnt;

endmodule

// File: tb/tb_fifo_word_packer.sv
// Bench for fifo_word_packer: queue-based FIFO model, directed cases and randomized streams
// checked against the word order pushed into the FIFO.
module tb_fifo_word_packer;
  import fifo_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;

  fifo_word_packer_if ifc ();

  fifo_word_packer #(
    .TIMEOUT (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .pk  (ifc)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [15:0] fq[$];
  logic [15:0] expq[$];
  logic [31:0] beats_d[$];
  logic [1:0]  beats_k[$];
  int          cyc = 0;
  int          first_re_cyc = -1;
  int          beat_cyc = -1;
  int          re_cnt = 0;
  bit          prev_re = 0;
  bit          flush_lvl = 0, ready_lvl = 0, rnd_ready = 0, rnd_flush = 0;
  int          gap_mode = 0, gap_run = 0, push_left = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] bd(input int i);
    return (i < beats_d.size()) ? beats_d[i] : 32'hxxxx_xxxx;
  endfunction

  function automatic logic [1:0] bk(input int i);
    return (i < beats_k.size()) ? beats_k[i] : 2'bxx;
  endfunction

  task automatic clear_log();
    beats_d.delete();
    beats_k.delete();
    expq.delete();
    re_cnt       = 0;
    first_re_cyc = -1;
    beat_cyc     = -1;
  endtask

  // One clock cycle, entered and left at the falling edge.
  task automatic step();
    logic [15:0] w;
    bit          gap;
    bit          was_re;
    if (prev_re && fq.size() > 0) ifc.fifo_dout = fq.pop_front();
    if (push_left > 0 && $urandom_range(0, 3) == 0) begin
      w = 16'($urandom);
      fq.push_back(w);
      expq.push_back(w);
      push_left--;
    end
    gap = 1'b0;
    if (gap_mode == 1)      gap = (gap_run < 2) && ($urandom_range(0, 2) == 0);
    else if (gap_mode == 2) gap = ($urandom_range(0, 1) == 0);
    gap_run = gap ? gap_run + 1 : 0;
    ifc.fifo_empty = gap || (fq.size() == 0);
    if (rnd_ready) ready_lvl = 1'($urandom_range(0, 1));
    if (rnd_flush) flush_lvl = ($urandom_range(0, 7) == 0);
    ifc.m_ready = ready_lvl;
    ifc.flush   = flush_lvl;
    #1;
    was_re  = prev_re;
    prev_re = rst && ifc.fifo_re;
    if (ifc.fifo_re) begin
      re_cnt++;
      if (first_re_cyc < 0) first_re_cyc = cyc;
      check("re_nonempty", 32'(ifc.fifo_empty), 0);
      check("re_single_outstanding", 32'(was_re), 0);
      check("re_outside_send", 32'(ifc.m_valid), 0);
    end
    if (ifc.m_valid) begin
      check("keep_nonzero", 32'(ifc.m_keep == 2'b00), 0);
      if (ifc.m_ready) begin
        beats_d.push_back(ifc.m_data);
        beats_k.push_back(ifc.m_keep);
        beat_cyc = cyc;
      end
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic run_until(input int nbeats, input int budget);
    int n = 0;
    while (beats_d.size() < nbeats && n < budget) begin
      step();
      n++;
    end
  endtask

  task automatic verify_stream(input string tag, input int nwords);
    logic [15:0] got[$];
    int          bad = 0;
    foreach (beats_d[i]) begin
      got.push_back(beats_d[i][15:0]);
      if (beats_k[i] == KEEP_FULL) got.push_back(beats_d[i][31:16]);
      else if (beats_k[i] != KEEP_HALF || beats_d[i][31:16] != 16'h0) bad++;
    end
    check({tag, "_words"}, got.size(), nwords);
    for (int i = 0; i < got.size() && i < expq.size(); i++)
      if (got[i] !== expq[i]) bad++;
    check({tag, "_order"}, bad, 0);
  endtask

  initial begin
    logic [31:0] d0;
    logic [1:0]  k0;
    logic [15:0] bc0;
    int          rc0, n, halves;
    ifc.fifo_empty = 1'b1;
    ifc.fifo_dout  = '0;
    ifc.flush      = 1'b0;
    ifc.m_ready    = 1'b0;
    @(negedge clk);

    // reset state with a preloaded FIFO, then the first full beat
    fq.push_back(16'h1111);
    fq.push_back(16'h2222);
    step();
    step();
    check("rst_fifo_re", 32'(ifc.fifo_re), 0);
    check("rst_m_valid", 32'(ifc.m_valid), 0);
    check("rst_m_data", ifc.m_data, 0);
    check("rst_m_keep", 32'(ifc.m_keep), 0);
    check("rst_beat_cnt", 32'(ifc.beat_cnt), 0);
    clear_log();
    rst = 1'b1;
    ready_lvl = 1'b1;
    repeat (12) step();
    check("t1_re_cnt", re_cnt, 2);
    check("t1_beats", beats_d.size(), 1);
    check("t1_data", bd(0), 32'h2222_1111);
    check("t1_keep", 32'(bk(0)), 32'(KEEP_FULL));
    check("t1_beat_cnt", 32'(ifc.beat_cnt), 1);
    check("t1_latency", beat_cyc - first_re_cyc, 4);

    // backpressure, with flush held high while in SEND
    clear_log();
    ready_lvl = 1'b0;
    fq.push_back(16'h3333); fq.push_back(16'h4444);
    fq.push_back(16'h5555); fq.push_back(16'h6666);
    n = 0;
    while (!ifc.m_valid && n < 20) begin step(); n++; end
    check("t2_valid", 32'(ifc.m_valid), 1);
    d0  = ifc.m_data;
    k0  = ifc.m_keep;
    rc0 = re_cnt;
    bc0 = ifc.beat_cnt;
    check("t2_data", d0, 32'h4444_3333);
    flush_lvl = 1'b1;
    repeat (10) begin
      step();
      check("t2_data_stable", ifc.m_data, d0);
      check("t2_keep_stable", 32'(ifc.m_keep), 32'(k0));
    end
    check("t2_no_re", re_cnt, rc0);
    flush_lvl = 1'b0;
    ready_lvl = 1'b1;
    step();
    check("t2_one_accept", beats_d.size(), 1);
    check("t2_cnt_once", 32'(ifc.beat_cnt), 32'(16'(bc0 + 16'd1)));
    run_until(2, 20);
    check("t2_next_beat", bd(1), 32'h6666_5555);
    check("t2_cnt_twice", 32'(ifc.beat_cnt), 32'(16'(bc0 + 16'd2)));

    // flush while idle in FILL_LO and while pending is ignored
    clear_log();
    flush_lvl = 1'b1;
    repeat (4) step();
    check("t3_idle_flush", beats_d.size(), 0);
    flush_lvl = 1'b0;
    fq.push_back(16'hABCD);
    step();
    flush_lvl = 1'b1;
    step();
    step();
    flush_lvl = 1'b0;
    run_until(1, 20);
    check("t3_data", bd(0), 32'h0000_ABCD);
    check("t3_keep", 32'(bk(0)), 32'(KEEP_HALF));
    check("t3_latency", beat_cyc - first_re_cyc, 3);

    // idle timeout with TIMEOUT=4
    clear_log();
    fq.push_back(16'h00FF);
    run_until(1, 20);
    check("t4_data", bd(0), 32'h0000_00FF);
    check("t4_keep", 32'(bk(0)), 32'(KEEP_HALF));
    check("t4_latency", beat_cyc - first_re_cyc, 6);

    // reset the cycle after the first capture discards the held word
    clear_log();
    fq.push_back(16'hDEAD);
    fq.push_back(16'hBEEF);
    step();
    step();
    rst = 1'b0;
    fq.delete();
    prev_re = 1'b0;
    step();
    step();
    check("t5_rst_cnt", 32'(ifc.beat_cnt), 0);
    check("t5_rst_valid", 32'(ifc.m_valid), 0);
    check("t5_rst_re", 32'(ifc.fifo_re), 0);
    rst = 1'b1;
    fq.push_back(16'h0001);
    fq.push_back(16'h0002);
    run_until(1, 20);
    repeat (6) step();
    check("t5_beats", beats_d.size(), 1);
    check("t5_data", bd(0), 32'h0002_0001);
    check("t5_beat_cnt", 32'(ifc.beat_cnt), 1);

    // 200 words, random ready, short empty gaps: all full beats
    clear_log();
    for (int i = 0; i < 200; i++) begin
      fq.push_back(16'($urandom));
      expq.push_back(fq[$]);
    end
    bc0 = ifc.beat_cnt;
    gap_mode  = 1;
    rnd_ready = 1'b1;
    run_until(100, 4000);
    rnd_ready = 1'b0;
    ready_lvl = 1'b1;
    gap_mode  = 0;
    repeat (10) step();
    check("ordA_beats", beats_d.size(), 100);
    halves = 0;
    foreach (beats_k[i]) if (beats_k[i] != KEEP_FULL) halves++;
    check("ordA_all_full", halves, 0);
    check("ordA_cnt", 32'(16'(ifc.beat_cnt - bc0)), 100);
    verify_stream("ordA", 200);

    // trickled words, long gaps, random flush: order preserved across half beats
    clear_log();
    bc0 = ifc.beat_cnt;
    push_left = 60;
    gap_mode  = 2;
    rnd_ready = 1'b1;
    rnd_flush = 1'b1;
    n = 0;
    while ((push_left > 0 || fq.size() > 0) && n < 3000) begin step(); n++; end
    rnd_flush = 1'b0;
    flush_lvl = 1'b0;
    rnd_ready = 1'b0;
    ready_lvl = 1'b1;
    gap_mode  = 0;
    repeat (30) step();
    verify_stream("ordB", 60);
    check("ordB_cnt", 32'(16'(ifc.beat_cnt - bc0)), beats_d.size());

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
